dct_in_framer: RTL and testbench
================================

DCT_IN_FRAMER -- requirements
Module: dct_in_framer

Interface
REQ-001 SHALL have parameter N, default 32, meaning sample word width and number of bit-serial DCT cycles per block.
REQ-002 SHALL have parameter NPTS, default 16, meaning samples per DCT block.
REQ-003 SHALL have parameter HOLD_CYC, default 32, meaning cycles the block bus stays frozen after init.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 s_data  input  N  serial sample stream, two's complement.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_ready  output  1  framer can accept s_data.
REQ-009 blk_out  output  NPTS*N  parallel block to DCT engine; word k at bits [k*N +: N], i.e. in0..in15.
REQ-010 init  output  1  one-cycle start pulse to DCT engine.
REQ-011 busy  output  1  DCT engine is processing the launched block.

Function
REQ-012 A sample SHALL transfer only on a cycle with s_valid=1 and s_ready=1; the k-th transfer of a block (k=0..NPTS-1) writes word k.
REQ-013 The FSM SHALL have states FILL, LAUNCH, HOLD.
REQ-014 FILL: s_ready=1; fill counter increments per transfer; the transfer of word NPTS-1 moves FSM to LAUNCH and clears the fill counter.
REQ-015 LAUNCH: init=1 for exactly one cycle; blk_out already shows the complete block; next state HOLD.
REQ-016 HOLD: busy=1; hold counter counts HOLD_CYC cycles starting the cycle after LAUNCH; at count HOLD_CYC-1 FSM returns to FILL.
REQ-017 blk_out SHALL be unchanged from the LAUNCH cycle through the last HOLD cycle.
REQ-018 Latency: word NPTS-1 accepted on edge t -> init=1 during cycle t+1; busy=1 cycles t+2..t+1+HOLD_CYC.
REQ-019 s_valid=0 during FILL SHALL stall the fill counter without losing words already stored.
REQ-020 init SHALL never be asserted in two consecutive cycles; init and busy SHALL never both be 1.

Reset
REQ-021 While rst_n=0 on a rising edge: FSM=FILL, fill and hold counters=0, init=0, busy=0, blk_out=0; s_ready=1 from the first cycle after reset.
REQ-022 Reset asserted mid-FILL or mid-HOLD SHALL discard the partial or running block; no init follows reset unless NPTS new words arrive.

Configuration
REQ-023 Macro DCT_IN_PINGPONG_EN SHALL select double buffering.
REQ-024 Without DCT_IN_PINGPONG_EN: single bank; s_ready=0 in LAUNCH and HOLD.
REQ-025 With DCT_IN_PINGPONG_EN: two banks; the fill bank keeps s_ready=1 during LAUNCH/HOLD until it is full; s_ready=0 only when the fill bank is full and the engine is not idle.
REQ-026 With DCT_IN_PINGPONG_EN, when the fill bank is full at the end of HOLD, LAUNCH SHALL follow on the next cycle with the banks swapped; blk_out switches to the new bank in the LAUNCH cycle.

Structure
REQ-027 A shared package SHALL hold the defaults for N, NPTS and HOLD_CYC, plus the FSM state enum.
REQ-028 One sub-module, dct_in_bank (NPTS x N register file with indexed write and flattened read), SHALL be instantiated once, or twice with DCT_IN_PINGPONG_EN.

Verification
REQ-029 Reset, then 16 back-to-back words 0x0051EB85 and 0x00624DD2 alternating -> init high one cycle after the 16th transfer; blk_out word0=0x0051EB85, word1=0x00624DD2.
REQ-030 After init -> busy high exactly 32 cycles; blk_out constant; s_ready=0 throughout (macro off).
REQ-031 Random s_valid gaps (about 50% duty) over 16 words 0..15 -> blk_out word k = k; single init.
REQ-032 rst_n low for 1 cycle after 9 words -> no init; the next 16 words produce a clean block with word0 = first post-reset word.
REQ-033 Macro on: 32 words streamed continuously -> second block fully accepted during HOLD of the first; second init exactly 1 cycle after first busy drops; no transfer lost.
REQ-034 s_valid held 1 with a 17th word waiting while the block is in HOLD (macro off) -> word not taken until FILL; it becomes word0 of the next block.

Source files
------------

// File: rtl/dct_in_framer_pkg.sv
// Shared defaults, FSM state encoding and a counter-width helper for the
// DCT input framer and its sample bank.
package dct_in_framer_pkg;

   localparam int N_DEF        = 32;
   localparam int NPTS_DEF     = 16;
   localparam int HOLD_CYC_DEF = 32;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_HOLD   = 2'd2
   } state_e;

   // Width of a counter that must hold values 0..n-1 (at least one bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dct_in_bank.sv
// NPTS x N sample register file: one indexed write port, all words read
// in parallel as a flattened bus (word k at bits [k*N +: N]).
module dct_in_bank
   import dct_in_framer_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int NPTS = NPTS_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        we,
   input  logic [cnt_w(NPTS)-1:0]      waddr,
   input  logic signed [N-1:0]         wdata,
   output logic [NPTS*N-1:0]           rdata
);

   logic signed [N-1:0] mem_q [NPTS];
   logic signed [N-1:0] mem_d [NPTS];

   // Next contents: copy current words, overwrite the addressed one on a write.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Storage; reset clears every word so a discarded block never leaks out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   // Flatten the word array onto the parallel read bus.
   always_comb begin
      rdata = '0;
      for (int k = 0; k < NPTS; k++) begin
         rdata[k*N +: N] = mem_q[k];
      end
   end

endmodule

// File: rtl/dct_in_framer.sv
// Collects NPTS serial samples into a parallel block, pulses init to the
// bit-serial DCT engine and keeps the block frozen while the engine runs.
// Optional double buffering: define DCT_IN_PINGPONG_EN to let the next block
// fill into a second bank while the engine works on the current one.
module dct_in_framer
   import dct_in_framer_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int NPTS     = NPTS_DEF,
   parameter int HOLD_CYC = HOLD_CYC_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic signed [N-1:0]  s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [NPTS*N-1:0]    blk_out,
   output logic                 init,
   output logic                 busy
);

   localparam int FW = cnt_w(NPTS);
   localparam int HW = cnt_w(HOLD_CYC);
   localparam logic [FW-1:0] FILL_LAST = FW'(NPTS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

   state_e          state_q,    state_d;
   logic [FW-1:0]   fill_cnt_q, fill_cnt_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic            xfer;
   logic            fill_last;

`ifdef DCT_IN_PINGPONG_EN
   logic            fill_bank_q, fill_bank_d;
   logic            eng_bank_q,  eng_bank_d;
   logic            fill_full_q, fill_full_d;
`endif

   // Handshake, fill/hold counting and FSM next-state; init/busy decode the state.
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      hold_cnt_d = hold_cnt_q;
      init       = (state_q == ST_LAUNCH);
      busy       = (state_q == ST_HOLD);
`ifdef DCT_IN_PINGPONG_EN
      fill_bank_d = fill_bank_q;
      eng_bank_d  = eng_bank_q;
      fill_full_d = fill_full_q;
      // The fill bank is independent of the engine; only a full bank stalls input.
      s_ready     = !fill_full_q;
`else
      // A single bank is shared with the engine, so input waits for FILL.
      s_ready     = (state_q == ST_FILL);
`endif
      xfer      = s_valid && s_ready;
      fill_last = xfer && (fill_cnt_q == FILL_LAST);

      if (xfer) begin
         fill_cnt_d = fill_last ? '0 : fill_cnt_q + 1'b1;
      end
`ifdef DCT_IN_PINGPONG_EN
      if (fill_last) begin
         fill_full_d = 1'b1;
      end
`endif

      case (state_q)
         ST_FILL: begin
            if (fill_last) begin
               state_d = ST_LAUNCH;
`ifdef DCT_IN_PINGPONG_EN
               // Hand the just-completed bank to the engine.
               eng_bank_d  = fill_bank_q;
               fill_bank_d = !fill_bank_q;
               fill_full_d = 1'b0;
`endif
            end
         end
         ST_LAUNCH: begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
         end
         ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_d = '0;
`ifdef DCT_IN_PINGPONG_EN
               if (fill_full_q || fill_last) begin
                  // Next block already waiting: launch it straight away.
                  state_d     = ST_LAUNCH;
                  eng_bank_d  = fill_bank_q;
                  fill_bank_d = !fill_bank_q;
                  fill_full_d = 1'b0;
               end else begin
                  state_d = ST_FILL;
               end
`else
               state_d = ST_FILL;
`endif
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   // Control registers; reset drops any partial or running block.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_FILL;
         fill_cnt_q <= '0;
         hold_cnt_q <= '0;
`ifdef DCT_IN_PINGPONG_EN
         fill_bank_q <= 1'b0;
         eng_bank_q  <= 1'b0;
         fill_full_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         hold_cnt_q <= hold_cnt_d;
`ifdef DCT_IN_PINGPONG_EN
         fill_bank_q <= fill_bank_d;
         eng_bank_q  <= eng_bank_d;
         fill_full_q <= fill_full_d;
`endif
      end
   end

`ifdef DCT_IN_PINGPONG_EN
   logic [NPTS*N-1:0] rd0;
   logic [NPTS*N-1:0] rd1;

   dct_in_bank #(.N(N), .NPTS(NPTS)) u_bank0 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (xfer && !fill_bank_q),
      .waddr (fill_cnt_q),
      .wdata (s_data),
      .rdata (rd0)
   );

   dct_in_bank #(.N(N), .NPTS(NPTS)) u_bank1 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (xfer && fill_bank_q),
      .waddr (fill_cnt_q),
      .wdata (s_data),
      .rdata (rd1)
   );

   assign blk_out = eng_bank_q ? rd1 : rd0;
`else
   dct_in_bank #(.N(N), .NPTS(NPTS)) u_bank0 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (xfer),
      .waddr (fill_cnt_q),
      .wdata (s_data),
      .rdata (blk_out)
   );
`endif

endmodule

// File: tb/tb_dct_in_framer.sv
// Directed bench for dct_in_framer (default parameters).
module tb_dct_in_framer;

   localparam int N        = 32;
   localparam int NPTS     = 16;
   localparam int HOLD_CYC = 32;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic signed [N-1:0]  s_data;
   logic                 s_valid;
   logic                 s_ready;
   logic [NPTS*N-1:0]    blk_out;
   logic                 init;
   logic                 busy;

   int n_tests = 0;
   int n_fail  = 0;

   dct_in_framer #(.N(N), .NPTS(NPTS), .HOLD_CYC(HOLD_CYC)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .blk_out (blk_out),
      .init    (init),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-1:0] v);
      s_valid = 1'b1;
      s_data  = v;
      step();
   endtask

   task automatic drain();
      s_valid = 1'b0;
      for (int i = 0; i < HOLD_CYC + 2; i++) step();
   endtask

   function automatic logic [N-1:0] word(input int k);
      return blk_out[k*N +: N];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
      step(); step();
      n_tests++; if (init !== 1'b0) begin n_fail++; $display("FAIL rst_init: got %0b want 0", init); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
      n_tests++; if (blk_out !== '0) begin n_fail++; $display("FAIL rst_blk: got %0h want 0", blk_out); end
      rst_n = 1'b1;
      step();
      n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", s_ready); end
      n_tests++; if (init !== 1'b0) begin n_fail++; $display("FAIL rst_idle_init: got %0b want 0", init); end
   endtask

   task automatic test_basic();
      logic [NPTS*N-1:0] saved;
      for (int i = 0; i < NPTS; i++) send((i % 2 == 0) ? 32'h0051EB85 : 32'h00624DD2);
      s_valid = 1'b0;
      n_tests++; if (init !== 1'b1) begin n_fail++; $display("FAIL basic_init: got %0b want 1", init); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_init: got %0b want 0", busy); end
      n_tests++; if (word(0) !== 32'h0051EB85) begin n_fail++; $display("FAIL basic_w0: got %0h want 0051eb85", word(0)); end
      n_tests++; if (word(1) !== 32'h00624DD2) begin n_fail++; $display("FAIL basic_w1: got %0h want 00624dd2", word(1)); end
      n_tests++; if (word(15) !== 32'h00624DD2) begin n_fail++; $display("FAIL basic_w15: got %0h want 00624dd2", word(15)); end
`ifndef DCT_IN_PINGPONG_EN
      n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_launch: got %0b want 0", s_ready); end
`endif
      saved = blk_out;
      for (int c = 1; c <= HOLD_CYC + 2; c++) begin
         step();
         n_tests++; if (busy !== (c <= HOLD_CYC)) begin n_fail++; $display("FAIL basic_busy c=%0d: got %0b want %0b", c, busy, (c <= HOLD_CYC)); end
         n_tests++; if (init !== 1'b0) begin n_fail++; $display("FAIL basic_init_hold c=%0d: got %0b want 0", c, init); end
         if (c <= HOLD_CYC) begin
            n_tests++; if (blk_out !== saved) begin n_fail++; $display("FAIL basic_frozen c=%0d: got %0h want %0h", c, blk_out, saved); end
`ifndef DCT_IN_PINGPONG_EN
            n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_hold c=%0d: got %0b want 0", c, s_ready); end
`endif
         end
      end
      n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %0b want 1", s_ready); end
   endtask

   task automatic test_gaps();
      int inits = 0;
      for (int k = 0; k < NPTS; k++) begin
         int gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) begin
            s_valid = 1'b0;
            s_data  = 32'hDEADBEEF;
            step();
            inits += int'(init);
         end
         send(N'(k));
         inits += int'(init);
      end
      s_valid = 1'b0;
      n_tests++; if (init !== 1'b1) begin n_fail++; $display("FAIL gaps_init: got %0b want 1", init); end
      for (int k = 0; k < NPTS; k++) begin
         n_tests++; if (word(k) !== N'(k)) begin n_fail++; $display("FAIL gaps_w%0d: got %0h want %0h", k, word(k), k); end
      end
      for (int c = 0; c < HOLD_CYC + 2; c++) begin
         step();
         inits += int'(init);
      end
      n_tests++; if (inits !== 1) begin n_fail++; $display("FAIL gaps_init_count: got %0d want 1", inits); end
   endtask

   task automatic test_reset_mid();
      int inits = 0;
      for (int i = 0; i < 9; i++) send(32'h100 + i);
      s_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_tests++; if (blk_out !== '0) begin n_fail++; $display("FAIL rmid_blk_cleared: got %0h want 0", blk_out); end
      n_tests++; if (init !== 1'b0) begin n_fail++; $display("FAIL rmid_init_after_rst: got %0b want 0", init); end
      for (int i = 0; i < NPTS; i++) begin
         send(32'h200 + i);
         if (i < NPTS - 1) inits += int'(init);
      end
      s_valid = 1'b0;
      n_tests++; if (inits !== 0) begin n_fail++; $display("FAIL rmid_early_init: got %0d want 0", inits); end
      n_tests++; if (init !== 1'b1) begin n_fail++; $display("FAIL rmid_init: got %0b want 1", init); end
      n_tests++; if (word(0) !== 32'h200) begin n_fail++; $display("FAIL rmid_w0: got %0h want 200", word(0)); end
      n_tests++; if (word(15) !== 32'h20F) begin n_fail++; $display("FAIL rmid_w15: got %0h want 20f", word(15)); end
      drain();
   endtask

`ifndef DCT_IN_PINGPONG_EN
   task automatic test_hold_wait();
      int waited = 0;
      for (int i = 0; i < NPTS; i++) send(32'h300 + i);
      s_valid = 1'b1;
      s_data  = 32'h3AA;
      while (!s_ready && waited < 40) begin
         step();
         waited++;
      end
      n_tests++; if (waited !== HOLD_CYC + 1) begin n_fail++; $display("FAIL hw_wait_cycles: got %0d want %0d", waited, HOLD_CYC + 1); end
      n_tests++; if (word(0) !== 32'h300) begin n_fail++; $display("FAIL hw_not_taken: got %0h want 300", word(0)); end
      step();
      for (int j = 1; j < NPTS; j++) send(32'h3B0 + j);
      s_valid = 1'b0;
      n_tests++; if (init !== 1'b1) begin n_fail++; $display("FAIL hw_init: got %0b want 1", init); end
      n_tests++; if (word(0) !== 32'h3AA) begin n_fail++; $display("FAIL hw_w0: got %0h want 3aa", word(0)); end
      n_tests++; if (word(1) !== 32'h3B1) begin n_fail++; $display("FAIL hw_w1: got %0h want 3b1", word(1)); end
      n_tests++; if (word(15) !== 32'h3BF) begin n_fail++; $display("FAIL hw_w15: got %0h want 3bf", word(15)); end
      drain();
   endtask
`endif

`ifdef DCT_IN_PINGPONG_EN
   task automatic test_pingpong();
      int idx = 0, c = 0, init1 = -1, init2 = -1, last_busy = -1, idx_at2 = -1;
      logic rdy40 = 1'b1;
      logic took;
      logic [NPTS*N-1:0] blk1 = '0, blk2 = '0;
      rst_n = 1'b0; s_valid = 1'b0;
      step();
      rst_n = 1'b1;
      while (c < 80) begin
         if (idx < 2*NPTS) begin
            s_valid = 1'b1;
            s_data  = 32'h400 + idx;
         end else begin
            s_valid = 1'b0;
         end
         took = s_valid && s_ready;
         step();
         c++;
         if (took) idx++;
         if (init) begin
            if (init1 < 0) begin init1 = c; blk1 = blk_out; end
            else if (init2 < 0) begin init2 = c; blk2 = blk_out; idx_at2 = idx; end
         end
         if (busy && init2 < 0) last_busy = c;
         if (c == 40) rdy40 = s_ready;
      end
      s_valid = 1'b0;
      n_tests++; if (init1 !== 16) begin n_fail++; $display("FAIL pp_init1_cycle: got %0d want 16", init1); end
      n_tests++; if (last_busy !== 48) begin n_fail++; $display("FAIL pp_last_busy: got %0d want 48", last_busy); end
      n_tests++; if (init2 !== 49) begin n_fail++; $display("FAIL pp_init2_cycle: got %0d want 49", init2); end
      n_tests++; if (idx_at2 !== 32) begin n_fail++; $display("FAIL pp_accepted: got %0d want 32", idx_at2); end
      n_tests++; if (rdy40 !== 1'b0) begin n_fail++; $display("FAIL pp_ready_full: got %0b want 0", rdy40); end
      n_tests++; if (blk1[0 +: N] !== 32'h400) begin n_fail++; $display("FAIL pp_b1_w0: got %0h want 400", blk1[0 +: N]); end
      n_tests++; if (blk1[15*N +: N] !== 32'h40F) begin n_fail++; $display("FAIL pp_b1_w15: got %0h want 40f", blk1[15*N +: N]); end
      n_tests++; if (blk2[0 +: N] !== 32'h410) begin n_fail++; $display("FAIL pp_b2_w0: got %0h want 410", blk2[0 +: N]); end
      n_tests++; if (blk2[15*N +: N] !== 32'h41F) begin n_fail++; $display("FAIL pp_b2_w15: got %0h want 41f", blk2[15*N +: N]); end
      drain();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_reset_mid();
`ifndef DCT_IN_PINGPONG_EN
      test_hold_wait();
`endif
`ifdef DCT_IN_PINGPONG_EN
      test_pingpong();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
